// File: rtl/sales_tally_pkg.sv
// Shared constants and FSM encoding for the per-slot sales tally.
// Latency: n/a. Backpressure: n/a.
// BCD digit width, slot count and saturation limits live here.
package sales_tally_pkg;

    localparam int          NUM_SLOTS    = 7;
    localparam logic [7:0]  MAX_BCD      = 8'h99;
    localparam logic [11:0] MAX_TOTAL    = 12'h999;
    localparam int          DIGIT_W      = 4;
    localparam int          SLOT_DIGITS  = 2;
    localparam int          TOTAL_DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_inc_sat.sv
// N-digit packed-BCD incrementer; holds its input and flags sat at SAT_VAL.
// Latency: combinational. Backpressure: none.
module bcd_inc_sat
    import sales_tally_pkg::*;
#(
    parameter int                         DIGITS  = 2,
    parameter logic [DIGIT_W*DIGITS-1:0]  SAT_VAL = {DIGITS{4'h9}}
) (
    input  logic [DIGIT_W*DIGITS-1:0] val,
    output logic [DIGIT_W*DIGITS-1:0] inc,
    output logic                      sat
);

    always_comb begin
        logic carry;
        inc   = val;
        carry = 1'b1;
        sat   = (val == SAT_VAL);
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (val[i*DIGIT_W +: DIGIT_W] >= 4'd9) begin
                    inc[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    inc[i*DIGIT_W +: DIGIT_W] = val[i*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (sat) inc = val;
    end

endmodule

// File: rtl/sales_tally.sv
// Per-slot 2-digit BCD sold counters plus 3-digit grand total, with ok/reject acks.
// Latency: ack pulse 2 cycles after a valid sale edge (1 for slot 0); view mux 1 cycle.
// Backpressure: sale edges arriving while busy are dropped, never queued.
module sales_tally
    import sales_tally_pkg::*;
(
    input  logic        clk,
    input  logic        EN,
    input  logic        sale,
    input  logic [2:0]  sale_slot,
    input  logic        clr,
    input  logic [2:0]  view_slot,
    output logic [3:0]  sold1,
    output logic [3:0]  sold2,
    output logic [11:0] total,
    output logic        sale_ok,
    output logic        sale_rej,
    output logic        busy
);

    state_t     state;
    logic       sale_d;
    logic       clr_d;
    logic [2:0] slot_q;
    logic [7:0] cnt [0:NUM_SLOTS];

    logic       sale_e;
    logic       clr_e;
    logic [7:0] slot_nxt;
    logic       slot_sat;
    logic [11:0] total_nxt;
    logic       total_sat;
    logic [7:0] view_nxt;

    assign sale_e = sale & ~sale_d;
    assign clr_e  = clr & ~clr_d;
    assign busy   = (state != ST_IDLE);

    bcd_inc_sat #(
        .DIGITS  (SLOT_DIGITS),
        .SAT_VAL (MAX_BCD)
    ) u_slot_inc (
        .val (cnt[slot_q]),
        .inc (slot_nxt),
        .sat (slot_sat)
    );

    bcd_inc_sat #(
        .DIGITS  (TOTAL_DIGITS),
        .SAT_VAL (MAX_TOTAL)
    ) u_total_inc (
        .val (total),
        .inc (total_nxt),
        .sat (total_sat)
    );

    // Forward the value being written in UPD so the display lines up with the ack.
    always_comb begin
        view_nxt = cnt[view_slot];
        if (view_slot == 3'd0) begin
            view_nxt = '0;
        end else if (state == ST_UPD && !slot_sat && view_slot == slot_q) begin
            view_nxt = slot_nxt;
        end
    end

    always_ff @(posedge clk or negedge EN) begin
        if (!EN) begin
            state    <= ST_IDLE;
            sale_d   <= 1'b1;
            clr_d    <= 1'b1;
            slot_q   <= '0;
            total    <= '0;
            sold1    <= '0;
            sold2    <= '0;
            sale_ok  <= 1'b0;
            sale_rej <= 1'b0;
            for (int i = 0; i <= NUM_SLOTS; i++) cnt[i] <= '0;
        end else begin
            sale_d   <= sale;
            clr_d    <= clr;
            sale_ok  <= 1'b0;
            sale_rej <= 1'b0;
            {sold2, sold1} <= view_nxt;
            if (clr_e) begin
                state <= ST_IDLE;
                total <= '0;
                sold1 <= '0;
                sold2 <= '0;
                for (int i = 0; i <= NUM_SLOTS; i++) cnt[i] <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (sale_e) begin
                            if (sale_slot == 3'd0) begin
                                sale_rej <= 1'b1;
                                state    <= ST_ACK;
                            end else begin
                                slot_q <= sale_slot;
                                state  <= ST_UPD;
                            end
                        end
                    end
                    ST_UPD: begin
                        if (slot_sat) begin
                            sale_rej <= 1'b1;
                        end else begin
                            sale_ok      <= 1'b1;
                            cnt[slot_q]  <= slot_nxt;
                            if (!total_sat) total <= total_nxt;
                        end
                        state <= ST_ACK;
                    end
                    ST_ACK:  state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
